sum_accumulator: RTL and testbench

- Downstream consumer of the 32-bit shift/add datapath result (`sum`).
- Accumulates a programmed number of signed 32-bit samples into a wider signed accumulator.
- Accepts samples over a valid/ready handshake and presents one result per burst on a valid/ready output handshake.
- Flags signed overflow of the accumulator. Sits between the shift/add stage and the result-collection logic.

---
 rtl/sum_accumulator.sv | 105 ++++++++++
 tb/tb_sum_accumulator.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// Burst accumulator: sums a programmed number of signed samples into a wider
// signed total and hands one result downstream per burst, with sticky overflow.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; last result and overflow remain visible
// ACCUM | accepting samples, one per in_valid cycle, until remaining hits 0
// DONE  | result presented on out_valid until out_ready completes the transfer
module sum_accumulator #(
   parameter int WIDTH     = 32,
   parameter int ACC_WIDTH = 40,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] count,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_sum,
   output logic                 out_overflow,
   output logic                 busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [ACC_WIDTH-1:0] acc_q;
   logic                 ovf_q;
   logic [CNT_WIDTH-1:0] remaining_q;

   logic [ACC_WIDTH-1:0] sample_ext;
   logic [ACC_WIDTH-1:0] acc_sum;
   logic                 add_ovf;
   logic                 beat;
   logic                 last_beat;

   assign sample_ext = {{(ACC_WIDTH-WIDTH){in_data[WIDTH-1]}}, in_data};
   assign acc_sum    = acc_q + sample_ext;
   // Signed overflow: like-signed operands producing a result of the other sign.
   assign add_ovf    = (acc_q[ACC_WIDTH-1] == sample_ext[ACC_WIDTH-1]) &&
                       (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
   assign beat       = (state_q == S_ACCUM) && in_valid;
   assign last_beat  = beat && (remaining_q == CNT_WIDTH'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = (count == '0) ? S_DONE : S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (last_beat) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         remaining_q <= '0;
      end else if ((state_q == S_IDLE) && start) begin
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         remaining_q <= count;
      end else if (beat) begin
         acc_q       <= acc_sum;
         ovf_q       <= ovf_q | add_ovf;
         remaining_q <= remaining_q - CNT_WIDTH'(1);
      end
   end

   assign in_ready     = (state_q == S_ACCUM);
   assign out_valid    = (state_q == S_DONE);
   assign busy         = (state_q != S_IDLE);
   assign out_sum      = acc_q;
   assign out_overflow = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: a 40-bit and a 33-bit instance share
// stimulus; expected results are queued at burst start and popped on handshake.
module tb_sum_accumulator;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  count;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;

   logic        in_ready, out_valid, out_overflow, busy;
   logic [39:0] out_sum;
   logic        in_ready_b, out_valid_b, out_overflow_b, busy_b;
   logic [32:0] out_sum_b;

   typedef struct {
      logic [39:0] sum;
      logic        ovf;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   int n_cmp = 0;
   int n_err = 0;
   int beat_cnt = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   sum_accumulator u_dut (
      .clk(clk), .reset(reset), .start(start), .count(count),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_overflow(out_overflow), .busy(busy)
   );

   sum_accumulator #(.ACC_WIDTH(33)) u_dut33 (
      .clk(clk), .reset(reset), .start(start), .count(count),
      .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_sum(out_sum_b),
      .out_overflow(out_overflow_b), .busy(busy_b)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [39:0] sa, input logic oa, input logic [32:0] sb, input logic ob);
      exp_t e;
      e.sum = sa; e.ovf = oa; q_a.push_back(e);
      e.sum = {7'b0, sb}; e.ovf = ob; q_b.push_back(e);
   endtask

   task automatic do_start(input logic [7:0] c);
      start = 1'b1;
      count = c;
      tick();
      start = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d);
      int n;
      in_valid = 1'b1;
      in_data  = d;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
      tick();
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (busy && n < 50) begin
         tick();
         n++;
      end
      check(nm, 64'(busy), 64'd0);
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!reset && in_valid && in_ready) beat_cnt++;
   end

   always @(negedge clk) begin
      exp_t e;
      if (!reset && out_valid && out_ready) begin
         if (q_a.size() == 0) begin
            check("unexpected_result_a", 64'(out_valid), 64'd0);
         end else begin
            e = q_a.pop_front();
            check("result_sum_a", 64'(out_sum), 64'(e.sum));
            check("result_ovf_a", 64'(out_overflow), 64'(e.ovf));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!reset && out_valid_b && out_ready) begin
         if (q_b.size() == 0) begin
            check("unexpected_result_b", 64'(out_valid_b), 64'd0);
         end else begin
            e = q_b.pop_front();
            check("result_sum_b", 64'(out_sum_b), 64'(e.sum[32:0]));
            check("result_ovf_b", 64'(out_overflow_b), 64'(e.ovf));
         end
      end
   end

   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog: simulation did not complete");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int bc0, c0;
      reset = 1'b1; start = 1'b0; count = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      repeat (5) tick();
      check("idle_in_ready", 64'(in_ready), 64'd0);
      check("idle_out_valid", 64'(out_valid), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_out_sum", 64'(out_sum), 64'd0);
      check("idle_out_ovf", 64'(out_overflow), 64'd0);

      // Burst of 4 back-to-back samples, downstream always ready
      out_ready = 1'b1;
      push(40'd100, 1'b0, 33'd100, 1'b0);
      bc0 = beat_cnt;
      do_start(8'd4);
      check("b4_in_ready", 64'(in_ready), 64'd1);
      check("b4_busy", 64'(busy), 64'd1);
      send_beat(32'd10);
      send_beat(32'd20);
      send_beat(32'd30);
      send_beat(32'd40);
      in_valid = 1'b0;
      check("b4_out_valid_latency", 64'(out_valid), 64'd1);
      check("b4_beats", 64'(beat_cnt - bc0), 64'd4);
      tick();
      check("b4_back_idle", 64'(busy), 64'd0);
      check("b4_sum_retained", 64'(out_sum), 64'd100);

      // Gapped beats, mixed signs, downstream stalls
      out_ready = 1'b0;
      push(40'hFF80000004, 1'b0, 33'h180000004, 1'b0);
      bc0 = beat_cnt;
      do_start(8'd3);
      send_beat(32'hFFFFFFFF);
      in_valid = 1'b0;
      tick(); tick();
      check("gap1_in_ready", 64'(in_ready), 64'd1);
      check("gap1_beats", 64'(beat_cnt - bc0), 64'd1);
      send_beat(32'd5);
      in_valid = 1'b0;
      tick(); tick();
      check("gap2_beats", 64'(beat_cnt - bc0), 64'd2);
      send_beat(32'h80000000);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("stall_out_valid", 64'(out_valid), 64'd1);
         check("stall_out_sum", 64'(out_sum), 64'hFF80000004);
         check("stall_in_ready", 64'(in_ready), 64'd0);
         tick();
      end
      check("b3_beats", 64'(beat_cnt - bc0), 64'd3);
      out_ready = 1'b1;
      tick();
      check("b3_back_idle", 64'(busy), 64'd0);

      // Zero-length burst goes straight to DONE with a cleared result
      out_ready = 1'b0;
      push(40'd0, 1'b0, 33'd0, 1'b0);
      do_start(8'd0);
      check("c0_out_valid", 64'(out_valid), 64'd1);
      check("c0_in_ready", 64'(in_ready), 64'd0);
      check("c0_out_sum", 64'(out_sum), 64'd0);
      check("c0_out_ovf", 64'(out_overflow), 64'd0);
      out_ready = 1'b1;
      tick();
      check("c0_back_idle", 64'(busy), 64'd0);

      // 255 x 0x7FFFFFFF: fits at 40 bits, wraps at 33 bits from the third beat
      out_ready = 1'b1;
      push(40'h7F7FFFFF01, 1'b0, 33'h17FFFFF01, 1'b1);
      bc0 = beat_cnt;
      do_start(8'd255);
      c0 = cyc;
      for (int i = 0; i < 255; i++) begin
         send_beat(32'h7FFFFFFF);
         if (i == 1) check("w33_ovf_after_2", 64'(out_overflow_b), 64'd0);
         if (i == 2) check("w33_ovf_after_3", 64'(out_overflow_b), 64'd1);
      end
      in_valid = 1'b0;
      check("b255_cycles", 64'(cyc - c0), 64'd255);
      check("b255_beats", 64'(beat_cnt - bc0), 64'd255);
      check("b255_out_valid", 64'(out_valid), 64'd1);
      check("b255_ovf_b_sticky", 64'(out_overflow_b), 64'd1);
      tick();
      check("b255_back_idle", 64'(busy), 64'd0);

      // Reset in the middle of a burst discards it
      out_ready = 1'b1;
      do_start(8'd4);
      send_beat(32'd1000);
      send_beat(32'd2000);
      in_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_sum", 64'(out_sum), 64'd0);
      push(40'd7, 1'b0, 33'd7, 1'b0);
      do_start(8'd1);
      send_beat(32'd7);
      in_valid = 1'b0;
      check("after_rst_out_valid", 64'(out_valid), 64'd1);
      tick();
      check("after_rst_idle", 64'(busy), 64'd0);
      check("after_rst_sum", 64'(out_sum), 64'd7);

      // start while ACCUM and DONE must not restart or reload count
      out_ready = 1'b0;
      push(40'd7, 1'b0, 33'd7, 1'b0);
      do_start(8'd2);
      start = 1'b1;
      count = 8'd9;
      send_beat(32'd3);
      start = 1'b0;
      send_beat(32'd4);
      in_valid = 1'b0;
      check("ign_done_after_2", 64'(out_valid), 64'd1);
      check("ign_sum", 64'(out_sum), 64'd7);
      start = 1'b1;
      count = 8'd0;
      tick();
      start = 1'b0;
      check("ign_done_hold", 64'(out_valid), 64'd1);
      check("ign_done_sum_hold", 64'(out_sum), 64'd7);
      out_ready = 1'b1;
      wait_idle("ign_back_idle");

      repeat (3) tick();
      check("queue_a_drained", 64'(q_a.size()), 64'd0);
      check("queue_b_drained", 64'(q_b.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
